// File: rtl/sar_result_avg_if.sv
// sar_result_avg_if: SAR result stream into the averager and averaged result handshake out.
interface sar_result_avg_if;
    logic [1:0] StateP;
    logic [7:0] SAROut;
    logic [1:0] AvgSel;
    logic       Clear;
    logic       Ready;
    logic [7:0] Result;
    logic       Valid;
    logic       Overrun;
    logic [3:0] WinCnt;
    modport master (output StateP, SAROut, AvgSel, Clear, Ready, input Result, Valid, Overrun, WinCnt);
    modport slave (input StateP, SAROut, AvgSel, Clear, Ready, output Result, Valid, Overrun, WinCnt);
endinterface

// File: rtl/sar_result_avg.sv
// sar_result_avg: windowed average of completed SAR conversions (1/2/4/8) with a one-deep output register.
module sar_result_avg (
    input logic Clock,
    input logic Reset,
    sar_result_avg_if.slave bus
);
    logic [1:0]  prev_state;
    logic [1:0]  win_sel;
    logic [1:0]  sel;
    logic [10:0] acc;
    logic [10:0] sum;
    logic [10:0] shifted;
    logic [3:0]  cnt_next;
    logic        done;
    logic        close;
    // Window size is taken from AvgSel only when a new window opens.
    always_comb begin
        done     = (prev_state == 2'b01 || prev_state == 2'b10) && bus.StateP == 2'b00;
        sel      = (bus.WinCnt == 4'd0) ? bus.AvgSel : win_sel;
        cnt_next = bus.WinCnt + 4'd1;
        close    = done && cnt_next == (4'd1 << sel);
        sum      = acc + {3'b000, bus.SAROut};
        shifted  = sum >> sel;
    end
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            prev_state  <= 2'b00;
            win_sel     <= 2'b00;
            acc         <= '0;
            bus.WinCnt  <= '0;
            bus.Result  <= '0;
            bus.Valid   <= 1'b0;
            bus.Overrun <= 1'b0;
        end else begin
            prev_state <= bus.StateP;
            if (bus.Clear) begin
                acc         <= '0;
                bus.WinCnt  <= '0;
                bus.Valid   <= 1'b0;
                bus.Overrun <= 1'b0;
            end else begin
                if (done) begin
                    if (bus.WinCnt == 4'd0) win_sel <= bus.AvgSel;
                    acc        <= close ? 11'd0 : sum;
                    bus.WinCnt <= close ? 4'd0 : cnt_next;
                end
                if (close && (!bus.Valid || bus.Ready)) begin
                    bus.Result <= shifted[7:0];
                    bus.Valid  <= 1'b1;
                end else if (close) begin
                    bus.Overrun <= 1'b1;
                end else if (bus.Valid && bus.Ready) begin
                    bus.Valid <= 1'b0;
                end
            end
        end
    end
endmodule
